// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings and
// default multiplier latency.
package mc_ctrl_pkg;

   localparam int MUL_LAT_DEF = 4;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      UNKNOWN  = 4'd10,
      MULEX    = 4'd11,
      MULWB    = 4'd12
   } state_t;

endpackage

// File: rtl/mc_lat_counter.sv
// Loadable down-counter with zero flag; times the multiplier execute phase.
module mc_lat_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_val;
      else if (i_dec && (r_count != '0))
         r_count <= r_count - 1'b1;
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle processor main controller: registered state, combinational
// datapath controls, sticky illegal-opcode flag and a timed multiply phase.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               IsMul,
   input  logic               CondEx,
   input  logic               MemReady,
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic               NextPC,
   output logic               RegW,
   output logic               MemW,
   output logic               Branch,
   output logic               ALUOp,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic               MemReq,
   output logic               MulStart,
   output logic               Illegal,
   output logic [STATE_W-1:0] dbg_state
);

   localparam int CNT_W = $clog2(MUL_LAT + 1);

   state_t           r_state;
   state_t           w_next;
   logic             r_illegal;
   logic [CNT_W-1:0] w_count;
   logic             w_zero;
   logic             w_load;
   logic             w_dec;
   logic             w_unused;

   assign w_unused = ^Funct[4:1];

   always_comb begin
      w_next = FETCH;
      case (r_state)
         FETCH:    w_next = MemReady ? DECODE : FETCH;
         DECODE: begin
            if (!CondEx)
               w_next = FETCH;
            else begin
               case (Op)
                  2'b00:   w_next = Funct[5] ? EXECUTEI : (IsMul ? MULEX : EXECUTER);
                  2'b01:   w_next = MEMADR;
                  2'b10:   w_next = BRANCH;
                  default: w_next = UNKNOWN;
               endcase
            end
         end
         EXECUTER: w_next = ALUWB;
         EXECUTEI: w_next = ALUWB;
         MEMADR:   w_next = Funct[0] ? MEMRD : MEMWR;
         MEMRD:    w_next = MemReady ? MEMWB : MEMRD;
         MEMWR:    w_next = MemReady ? FETCH : MEMWR;
         MULEX:    w_next = w_zero ? MULWB : MULEX;
         default:  w_next = FETCH;
      endcase
   end

   // Counter is primed on the DECODE->MULEX edge so the first MULEX cycle holds MUL_LAT-1.
   assign w_load = (r_state == DECODE) && (w_next == MULEX);
   assign w_dec  = (r_state == MULEX) && !w_zero;

   mc_lat_counter #(.W(CNT_W)) u_lat (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (CNT_W'(MUL_LAT - 1)),
      .i_dec      (w_dec),
      .o_count    (w_count),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == UNKNOWN)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      MemReq    = 1'b0;
      MulStart  = 1'b0;
      case (r_state)
         FETCH: begin
            MemReq    = 1'b1;
            IRWrite   = MemReady;
            NextPC    = MemReady;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         EXECUTER: ALUOp = 1'b1;
         EXECUTEI: begin
            ALUOp   = 1'b1;
            ALUSrcB = 2'b01;
         end
         ALUWB:    RegW = 1'b1;
         MEMADR:   ALUSrcB = 2'b01;
         MEMRD: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
         end
         MEMWB: begin
            RegW      = 1'b1;
            ResultSrc = 2'b01;
         end
         MEMWR: begin
            MemReq = 1'b1;
            MemW   = 1'b1;
            AdrSrc = 1'b1;
         end
         BRANCH: begin
            Branch    = 1'b1;
            ResultSrc = 2'b10;
            ALUSrcB   = 2'b01;
         end
         MULEX:    MulStart = (w_count == CNT_W'(MUL_LAT - 1));
         MULWB: begin
            RegW      = 1'b1;
            ResultSrc = 2'b11;
         end
         default: ;
      endcase
   end

   assign Illegal   = r_illegal;
   assign dbg_state = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class cycle by cycle
// against hand-written state/control tables.
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       IsMul, CondEx, MemReady;
   logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic       MemReq, MulStart, Illegal;
   logic [3:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.MUL_LAT(MUL_LAT_DEF), .STATE_W(4)) u_dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul),
      .CondEx(CondEx), .MemReady(MemReady), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
      .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .MemReq(MemReq), .MulStart(MulStart), .Illegal(Illegal), .dbg_state(dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; Op = 2'b00; Funct = 6'd0; IsMul = 1'b0; CondEx = 1'b1; MemReady = 1'b0;
      tick();
      tick();
      n_checks++; if (dbg_state !== 4'(FETCH)) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, FETCH); end
      n_checks++; if (Illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", Illegal); end
      n_checks++; if ({MemReq, IRWrite, NextPC, RegW, MemW} !== 5'b10000) begin n_fail++; $display("FAIL reset_ctl_mr0: got %b want 10000", {MemReq, IRWrite, NextPC, RegW, MemW}); end
      n_checks++; if ({ALUSrcA, ALUSrcB, ResultSrc} !== 6'b011010) begin n_fail++; $display("FAIL reset_mux: got %b want 011010", {ALUSrcA, ALUSrcB, ResultSrc}); end
      MemReady = 1'b1;
      #1;
      n_checks++; if ({IRWrite, NextPC} !== 2'b11) begin n_fail++; $display("FAIL reset_irwrite_mr1: got %b want 11", {IRWrite, NextPC}); end
      tick();
      n_checks++; if (dbg_state !== 4'(FETCH)) begin n_fail++; $display("FAIL reset_hold: got %0d want %0d", dbg_state, FETCH); end
      reset = 1'b0;
      MemReady = 1'b0;
      tick();
      n_checks++; if (dbg_state !== 4'(FETCH)) begin n_fail++; $display("FAIL fetch_wait: got %0d want %0d", dbg_state, FETCH); end
      $display("test_reset done");
   endtask

   task automatic test_add();
      state_t exp_st [5] = '{FETCH, DECODE, EXECUTER, ALUWB, FETCH};
      Op = 2'b00; Funct = 6'b000100; IsMul = 1'b0; CondEx = 1'b1; MemReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (dbg_state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL add_state cyc%0d: got %0d want %0d", i, dbg_state, exp_st[i]); end
         n_checks++; if (RegW !== (exp_st[i] == ALUWB)) begin n_fail++; $display("FAIL add_regw cyc%0d: got %b", i, RegW); end
         if (exp_st[i] == EXECUTER) begin
            n_checks++; if ({ALUOp, ALUSrcA, ALUSrcB} !== 5'b10000) begin n_fail++; $display("FAIL add_exec_ctl: got %b want 10000", {ALUOp, ALUSrcA, ALUSrcB}); end
         end
         if (exp_st[i] == ALUWB) begin
            n_checks++; if (ResultSrc !== 2'b00) begin n_fail++; $display("FAIL add_wb_rsrc: got %b want 00", ResultSrc); end
         end
         if (i < 4) tick();
      end
      $display("test_add done");
   endtask

   task automatic test_ldr();
      state_t exp_st [9] = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMRD, MEMWB, FETCH};
      logic   mr     [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      Op = 2'b01; Funct = 6'b000001; IsMul = 1'b0; CondEx = 1'b1;
      for (int i = 0; i < 9; i++) begin
         MemReady = mr[i];
         #1;
         n_checks++; if (dbg_state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL ldr_state cyc%0d: got %0d want %0d", i, dbg_state, exp_st[i]); end
         n_checks++; if (RegW !== (exp_st[i] == MEMWB)) begin n_fail++; $display("FAIL ldr_regw cyc%0d: got %b", i, RegW); end
         if (exp_st[i] == MEMRD) begin
            n_checks++; if ({MemReq, AdrSrc, MemW} !== 3'b110) begin n_fail++; $display("FAIL ldr_memrd_ctl cyc%0d: got %b want 110", i, {MemReq, AdrSrc, MemW}); end
         end
         if (exp_st[i] == MEMWB) begin
            n_checks++; if (ResultSrc !== 2'b01) begin n_fail++; $display("FAIL ldr_wb_rsrc: got %b want 01", ResultSrc); end
         end
         if (i < 8) tick();
      end
      $display("test_ldr done");
   endtask

   task automatic test_str();
      state_t exp_st [5] = '{FETCH, DECODE, MEMADR, MEMWR, FETCH};
      Op = 2'b01; Funct = 6'b000000; IsMul = 1'b0; CondEx = 1'b1; MemReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (dbg_state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL str_state cyc%0d: got %0d want %0d", i, dbg_state, exp_st[i]); end
         n_checks++; if (MemW !== (exp_st[i] == MEMWR)) begin n_fail++; $display("FAIL str_memw cyc%0d: got %b", i, MemW); end
         if (exp_st[i] == MEMWR) begin
            n_checks++; if ({MemReq, AdrSrc, RegW} !== 3'b110) begin n_fail++; $display("FAIL str_memwr_ctl: got %b want 110", {MemReq, AdrSrc, RegW}); end
         end
         if (i < 4) tick();
      end
      $display("test_str done");
   endtask

   task automatic test_mul();
      state_t exp_st [8] = '{FETCH, DECODE, MULEX, MULEX, MULEX, MULEX, MULWB, FETCH};
      logic   exp_ms [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      Op = 2'b00; Funct = 6'b000000; IsMul = 1'b1; CondEx = 1'b1; MemReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_checks++; if (dbg_state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL mul_state cyc%0d: got %0d want %0d", i, dbg_state, exp_st[i]); end
         n_checks++; if (MulStart !== exp_ms[i]) begin n_fail++; $display("FAIL mul_start cyc%0d: got %b want %b", i, MulStart, exp_ms[i]); end
         n_checks++; if (RegW !== (exp_st[i] == MULWB)) begin n_fail++; $display("FAIL mul_regw cyc%0d: got %b", i, RegW); end
         if (exp_st[i] == MULWB) begin
            n_checks++; if (ResultSrc !== 2'b11) begin n_fail++; $display("FAIL mul_wb_rsrc: got %b want 11", ResultSrc); end
         end
         if (i < 7) tick();
      end
      IsMul = 1'b0;
      $display("test_mul done");
   endtask

   task automatic test_branch_execi();
      state_t exp_b [4] = '{FETCH, DECODE, BRANCH, FETCH};
      state_t exp_i [4] = '{FETCH, DECODE, EXECUTEI, ALUWB};
      Op = 2'b10; Funct = 6'b000000; IsMul = 1'b0; CondEx = 1'b1; MemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (dbg_state !== 4'(exp_b[i])) begin n_fail++; $display("FAIL br_state cyc%0d: got %0d want %0d", i, dbg_state, exp_b[i]); end
         n_checks++; if (Branch !== (exp_b[i] == BRANCH)) begin n_fail++; $display("FAIL br_branch cyc%0d: got %b", i, Branch); end
         if (exp_b[i] == BRANCH) begin
            n_checks++; if ({ALUSrcB, ResultSrc, RegW} !== 5'b01100) begin n_fail++; $display("FAIL br_ctl: got %b want 01100", {ALUSrcB, ResultSrc, RegW}); end
         end
         if (i < 3) tick();
      end
      Op = 2'b00; Funct = 6'b100000;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (dbg_state !== 4'(exp_i[i])) begin n_fail++; $display("FAIL execi_state cyc%0d: got %0d want %0d", i, dbg_state, exp_i[i]); end
         if (exp_i[i] == EXECUTEI) begin
            n_checks++; if ({ALUOp, ALUSrcA, ALUSrcB} !== 5'b10001) begin n_fail++; $display("FAIL execi_ctl: got %b want 10001", {ALUOp, ALUSrcA, ALUSrcB}); end
         end
         tick();
      end
      $display("test_branch_execi done");
   endtask

   task automatic test_condex();
      state_t exp_st [3] = '{FETCH, DECODE, FETCH};
      Op = 2'b10; Funct = 6'b000000; IsMul = 1'b0; CondEx = 1'b0; MemReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (dbg_state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL condex_state cyc%0d: got %0d want %0d", i, dbg_state, exp_st[i]); end
         n_checks++; if (Branch !== 1'b0) begin n_fail++; $display("FAIL condex_branch cyc%0d: got %b want 0", i, Branch); end
         if (i < 2) tick();
      end
      MemReady = 1'b0;
      tick();
      CondEx = 1'b1;
      $display("test_condex done");
   endtask

   task automatic test_illegal();
      state_t exp_st [4] = '{FETCH, DECODE, UNKNOWN, FETCH};
      logic   exp_il [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      Op = 2'b11; Funct = 6'b000000; CondEx = 1'b1; MemReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (dbg_state !== 4'(exp_st[i])) begin n_fail++; $display("FAIL ill_state cyc%0d: got %0d want %0d", i, dbg_state, exp_st[i]); end
         n_checks++; if (Illegal !== exp_il[i]) begin n_fail++; $display("FAIL ill_flag cyc%0d: got %b want %b", i, Illegal, exp_il[i]); end
         if (exp_st[i] == UNKNOWN) begin
            n_checks++; if ({RegW, MemW, IRWrite, NextPC, Branch, MemReq} !== 6'b000000) begin n_fail++; $display("FAIL ill_we: got %b want 000000", {RegW, MemW, IRWrite, NextPC, Branch, MemReq}); end
         end
         if (i < 3) tick();
      end
      Op = 2'b00; Funct = 6'b000100;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++; if (Illegal !== 1'b1) begin n_fail++; $display("FAIL ill_sticky cyc%0d: got %b want 1", i, Illegal); end
      end
      $display("test_illegal done");
   endtask

   task automatic test_reset_mulex();
      Op = 2'b00; Funct = 6'b000000; IsMul = 1'b1; CondEx = 1'b1; MemReady = 1'b1;
      for (int i = 0; i < 8 && dbg_state != 4'(FETCH); i++) tick();
      tick();
      tick();
      tick();
      #1;
      n_checks++; if (dbg_state !== 4'(MULEX)) begin n_fail++; $display("FAIL rstmul_pre: got %0d want %0d", dbg_state, MULEX); end
      reset = 1'b1;
      #1;
      n_checks++; if (dbg_state !== 4'(FETCH)) begin n_fail++; $display("FAIL rstmul_state: got %0d want %0d", dbg_state, FETCH); end
      n_checks++; if (u_dut.w_count !== 3'd0) begin n_fail++; $display("FAIL rstmul_count: got %0d want 0", u_dut.w_count); end
      n_checks++; if (Illegal !== 1'b0) begin n_fail++; $display("FAIL rstmul_illegal: got %b want 0", Illegal); end
      n_checks++; if ({MemReq, RegW, MulStart} !== 3'b100) begin n_fail++; $display("FAIL rstmul_ctl: got %b want 100", {MemReq, RegW, MulStart}); end
      tick();
      reset = 1'b0;
      MemReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++; if ({dbg_state, RegW} !== {4'(FETCH), 1'b0}) begin n_fail++; $display("FAIL rstmul_after cyc%0d: state=%0d regw=%b want %0d/0", i, dbg_state, RegW, FETCH); end
      end
      $display("test_reset_mulex done");
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_add();
      test_ldr();
      test_str();
      test_mul();
      test_branch_execi();
      test_condex();
      test_illegal();
      test_reset_mulex();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
